// File: rtl/ms_fpu_muldiv.sv
// Iterative shared mantissa multiplier (shift-add) / restoring divider for the FPU.
// Define MS_FPU_MULDIV_RADIX4_EN to retire two multiplier bits per multiply iteration.
module ms_fpu_muldiv (
  input  logic        AClkH,
  input  logic        AResetH,
  input  logic        AClkHEn,
  input  logic [31:0] AMulDivDataS,
  input  logic [31:0] AMulDivDataD,
  input  logic [1:0]  AMulDivStart,
  output logic [31:0] AMulDivDataR,
  output logic [31:0] AMulDivDataH,
  output logic        AMulDivWrEn
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;

  localparam logic [4:0] DivIters = 5'd29;

  stateT       state;
  logic [4:0]  iterCount;
  logic [23:0] opS;
  logic [24:0] rem;
  logic [28:0] quot;

  logic        unusedHighBits;
  assign unusedHighBits = ^{AMulDivDataS[31:24], AMulDivDataD[31:24]};

  // Product register: accumulator in the upper part, multiplier shifting out of the bottom.
`ifdef MS_FPU_MULDIV_RADIX4_EN
  localparam logic [4:0] MulIters = 5'd12;
  localparam int ProdW = 50;
  logic [ProdW-1:0] prod, prodNext;
  logic [25:0]      s3, addend, mulSum;

  always_comb begin
    addend = '0;
    case (prod[1:0])
      2'd1:    addend = {2'b00, opS};
      2'd2:    addend = {1'b0, opS, 1'b0};
      2'd3:    addend = s3;
      default: addend = '0;
    endcase
    mulSum   = prod[49:24] + addend;
    prodNext = {2'b00, mulSum, prod[23:2]};
  end
`else
  localparam logic [4:0] MulIters = 5'd24;
  localparam int ProdW = 49;
  logic [ProdW-1:0] prod, prodNext;
  logic [24:0]      mulSum;

  always_comb begin
    mulSum   = prod[48:24] + (prod[0] ? {1'b0, opS} : 25'd0);
    prodNext = {1'b0, mulSum, prod[23:1]};
  end
`endif

  // Restoring step: dividend bits enter from the top of quot as quotient bits fill the bottom.
  logic [25:0] divShift;
  logic [24:0] divDiff, remNext;
  logic [28:0] quotNext;
  logic        qBit;

  always_comb begin
    divShift = {rem, quot[28]};
    qBit     = divShift >= {2'b00, opS};
    divDiff  = divShift[24:0] - {1'b0, opS};
    remNext  = qBit ? divDiff : divShift[24:0];
    quotNext = {quot[27:0], qBit};
  end

  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      state        <= IDLE;
      iterCount    <= '0;
      opS          <= '0;
      prod         <= '0;
      rem          <= '0;
      quot         <= '0;
      AMulDivDataR <= '0;
      AMulDivDataH <= '0;
      AMulDivWrEn  <= 1'b0;
`ifdef MS_FPU_MULDIV_RADIX4_EN
      s3           <= '0;
`endif
    end else if (AClkHEn) begin
      if (AMulDivStart[0]) begin
        state       <= MUL;
        iterCount   <= MulIters;
        opS         <= AMulDivDataS[23:0];
        prod        <= ProdW'(AMulDivDataD[23:0]);
        AMulDivWrEn <= 1'b0;
`ifdef MS_FPU_MULDIV_RADIX4_EN
        s3          <= {2'b00, AMulDivDataS[23:0]} + {1'b0, AMulDivDataS[23:0], 1'b0};
`endif
      end else if (AMulDivStart[1]) begin
        state       <= DIV;
        iterCount   <= DivIters;
        opS         <= AMulDivDataS[23:0];
        rem         <= {2'b00, AMulDivDataD[23:1]};
        quot        <= {AMulDivDataD[0], 28'd0};
        AMulDivWrEn <= 1'b0;
      end else begin
        case (state)
          MUL: begin
            prod      <= prodNext;
            iterCount <= iterCount - 5'd1;
            if (iterCount == 5'd1) begin
              state        <= DONE;
              AMulDivDataR <= {3'b000, prodNext[47:19]};
              AMulDivDataH <= {13'd0, prodNext[18:0]};
              AMulDivWrEn  <= 1'b1;
            end
          end
          DIV: begin
            rem       <= remNext;
            quot      <= quotNext;
            iterCount <= iterCount - 5'd1;
            if (iterCount == 5'd1) begin
              state        <= DONE;
              AMulDivDataR <= (opS == 24'd0) ? 32'h1FFFFFFF : {3'b000, quotNext};
              AMulDivDataH <= (opS == 24'd0) ? 32'h0 : {7'd0, remNext};
              AMulDivWrEn  <= 1'b1;
            end
          end
          DONE: begin
            state       <= IDLE;
            AMulDivWrEn <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ms_fpu_muldiv.sv
// Directed + scoreboard testbench for ms_fpu_muldiv (expected results queued at start,
// popped when WrEn appears).
module tb_ms_fpu_muldiv;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] h;
  } resT;

`ifdef MS_FPU_MULDIV_RADIX4_EN
  localparam int MulLat = 12;
`else
  localparam int MulLat = 24;
`endif
  localparam int DivLat = 29;

  logic        AClkH = 1'b0;
  logic        AResetH = 1'b1;
  logic        AClkHEn = 1'b0;
  logic [31:0] AMulDivDataS = '0;
  logic [31:0] AMulDivDataD = '0;
  logic [1:0]  AMulDivStart = '0;
  logic [31:0] AMulDivDataR, AMulDivDataH;
  logic        AMulDivWrEn;

  int  total = 0;
  int  bad = 0;
  int  pulses = 0;
  int  pushed = 0;
  bit  wrEnPrev = 1'b0;
  resT sb[$];

  ms_fpu_muldiv dut (
    .AClkH(AClkH),
    .AResetH(AResetH),
    .AClkHEn(AClkHEn),
    .AMulDivDataS(AMulDivDataS),
    .AMulDivDataD(AMulDivDataD),
    .AMulDivStart(AMulDivStart),
    .AMulDivDataR(AMulDivDataR),
    .AMulDivDataH(AMulDivDataH),
    .AMulDivWrEn(AMulDivWrEn)
  );

  always #5 AClkH = ~AClkH;

  // Count WrEn pulses independently so spurious or aborted results are caught.
  always @(negedge AClkH) begin
    if (AMulDivWrEn && !wrEnPrev) pulses++;
    wrEnPrev = AMulDivWrEn;
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic resT model(input bit isDiv, input logic [31:0] s, input logic [31:0] d);
    resT         res;
    logic [63:0] p, n, q, rm;
    if (!isDiv) begin
      p = 64'(s[23:0]) * 64'(d[23:0]);
      res.r = {3'b000, p[47:19]};
      res.h = {13'd0, p[18:0]};
    end else if (s[23:0] == 24'd0) begin
      res.r = 32'h1FFFFFFF;
      res.h = 32'h0;
    end else begin
      n  = 64'(d[23:0]) << 28;
      q  = n / 64'(s[23:0]);
      rm = n % 64'(s[23:0]);
      res.r = {3'b000, q[28:0]};
      res.h = {7'd0, rm[24:0]};
    end
    return res;
  endfunction

  // Called at a negedge; returns at the negedge just after the start edge E0.
  task automatic applyStimulus(input logic [1:0] start, input logic [31:0] s, input logic [31:0] d,
                               input bit push, input resT exp);
    AClkHEn      = 1'b1;
    AMulDivStart = start;
    AMulDivDataS = s;
    AMulDivDataD = d;
    if (push) begin
      sb.push_back(exp);
      pushed++;
    end
    @(negedge AClkH);
    AMulDivStart = 2'b00;
    AMulDivDataS = $urandom;
    AMulDivDataD = $urandom;
  endtask

  task automatic checkOutput(input string tag, input int expLat, input bit stall);
    int  edges = 0;
    int  cyc = 0;
    bit  seen = 1'b0;
    resT exp;
    while (!seen && cyc < 200) begin
      if (stall) AClkHEn = cyc[0];
      @(posedge AClkH);
      if (AClkHEn) edges++;
      @(negedge AClkH);
      cyc++;
      if (AMulDivWrEn) seen = 1'b1;
    end
    check32({tag, ".seen"}, 32'(seen), 32'd1);
    check32({tag, ".latency"}, edges, expLat);
    if (sb.size() == 0) begin
      check32({tag, ".sbSize"}, 32'd0, 32'd1);
      exp = '0;
    end else begin
      exp = sb.pop_front();
    end
    check32({tag, ".R"}, AMulDivDataR, exp.r);
    check32({tag, ".H"}, AMulDivDataH, exp.h);
    if (stall) begin
      AClkHEn = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge AClkH);
        check32({tag, ".wrEnHeld"}, 32'(AMulDivWrEn), 32'd1);
        check32({tag, ".rHeld"}, AMulDivDataR, exp.r);
      end
    end
    AClkHEn = 1'b1;
    @(negedge AClkH);
    check32({tag, ".wrEnDrop"}, 32'(AMulDivWrEn), 32'd0);
    check32({tag, ".rHold"}, AMulDivDataR, exp.r);
  endtask

  initial begin
    resT         e;
    logic [31:0] s, d;

    repeat (3) @(negedge AClkH);
    check32("reset.R", AMulDivDataR, 32'h0);
    check32("reset.H", AMulDivDataH, 32'h0);
    check32("reset.WrEn", 32'(AMulDivWrEn), 32'd0);
    AResetH = 1'b0;
    AClkHEn = 1'b1;
    @(negedge AClkH);

    $display("[TB] multiply directed cases");
    applyStimulus(2'b01, 32'h00800000, 32'h00800000, 1, '{r: 32'h08000000, h: 32'h0});
    checkOutput("mulNorm", MulLat, 0);
    applyStimulus(2'b01, 32'hAB800000, 32'h5A800000, 1, '{r: 32'h08000000, h: 32'h0});
    checkOutput("mulHighBitsIgnored", MulLat, 0);
    applyStimulus(2'b01, 32'h00FFFFFF, 32'h00FFFFFF, 1, '{r: 32'h1FFFFFC0, h: 32'h00000001});
    checkOutput("mulMax", MulLat, 0);
    applyStimulus(2'b11, 32'h00FFFFFF, 32'h00FFFFFF, 1, '{r: 32'h1FFFFFC0, h: 32'h00000001});
    checkOutput("mulPriority", MulLat, 0);

    $display("[TB] divide directed cases");
    applyStimulus(2'b10, 32'h00C00000, 32'h00800000, 1, '{r: 32'h0AAAAAAA, h: 32'h00800000});
    checkOutput("divThird", DivLat, 0);
    applyStimulus(2'b10, 32'h00800000, 32'h00800000, 1, '{r: 32'h10000000, h: 32'h0});
    checkOutput("divEqual", DivLat, 0);
    applyStimulus(2'b10, 32'h00000000, 32'h00800000, 1, '{r: 32'h1FFFFFFF, h: 32'h0});
    checkOutput("divZero", DivLat, 0);

    $display("[TB] random multiplies and normalised divides");
    for (int i = 0; i < 3; i++) begin
      s = $urandom;
      d = $urandom;
      e = model(0, s, d);
      applyStimulus(2'b01, s, d, 1, e);
      checkOutput("mulRand", MulLat, 0);
    end
    for (int i = 0; i < 3; i++) begin
      s = $urandom | 32'h00800000;
      d = $urandom | 32'h00800000;
      e = model(1, s, d);
      applyStimulus(2'b10, s, d, 1, e);
      checkOutput("divRand", DivLat, 0);
    end

    $display("[TB] clock enable at 50 percent during multiply");
    applyStimulus(2'b01, 32'h00FFFFFF, 32'h00FFFFFF, 1, '{r: 32'h1FFFFFC0, h: 32'h00000001});
    checkOutput("mulStall", MulLat, 1);

    $display("[TB] divide aborted by multiply at E0+10");
    applyStimulus(2'b10, 32'h00C00000, 32'h00800000, 0, '0);
    repeat (9) @(negedge AClkH);
    applyStimulus(2'b01, 32'h00800000, 32'h00800000, 1, '{r: 32'h08000000, h: 32'h0});
    checkOutput("mulAfterAbort", MulLat, 0);

    $display("[TB] reset mid divide");
    applyStimulus(2'b10, 32'h00C00000, 32'h00800000, 0, '0);
    repeat (5) @(negedge AClkH);
    AResetH = 1'b1;
    @(negedge AClkH);
    check32("midReset.R", AMulDivDataR, 32'h0);
    check32("midReset.H", AMulDivDataH, 32'h0);
    check32("midReset.WrEn", 32'(AMulDivWrEn), 32'd0);
    AResetH = 1'b0;
    repeat (40) @(negedge AClkH);
    check32("midReset.idleWrEn", 32'(AMulDivWrEn), 32'd0);
    applyStimulus(2'b10, 32'h00800000, 32'h00800000, 1, '{r: 32'h10000000, h: 32'h0});
    checkOutput("divAfterReset", DivLat, 0);

    check32("pulseCount", pulses, pushed);
    check32("sbEmpty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
